// File: rtl/key_word_gen_if.sv
// Handshake/bus bundle for the AES key-schedule word generator.
//   Start/KeyLen/Key : schedule request from the controller
//   Cnt              : word index from the external key-expansion counter
//   Cnt_En/Cnt_Clr_n : enable and active-low clear back to that counter
//   Word_Out/Word_Idx/Word_Vld/Word_Rdy : round-key word stream to the key store
//   Busy/Done        : status
// Modports: master = surrounding system (controller, counter, key store);
//           slave  = key_word_gen.
interface key_word_gen_if;
    logic         Start;
    logic [1:0]   KeyLen;
    logic [255:0] Key;
    logic [5:0]   Cnt;
    logic         Cnt_En;
    logic         Cnt_Clr_n;
    logic [31:0]  Word_Out;
    logic [5:0]   Word_Idx;
    logic         Word_Vld;
    logic         Word_Rdy;
    logic         Busy;
    logic         Done;

    modport master (
        output Start, KeyLen, Key, Cnt, Word_Rdy,
        input  Cnt_En, Cnt_Clr_n, Word_Out, Word_Idx, Word_Vld, Busy, Done
    );

    modport slave (
        input  Start, KeyLen, Key, Cnt, Word_Rdy,
        output Cnt_En, Cnt_Clr_n, Word_Out, Word_Idx, Word_Vld, Busy, Done
    );
endinterface

// File: rtl/key_word_gen.sv
// AES key-schedule word generator (AES-128/192/256, selected per schedule).
// Emits w[0..Nw-1] in order, one per Word_Vld & Word_Rdy handshake, using the external
// key-expansion counter value Cnt as the word index.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-low reset
//   bus  : key_word_gen_if.slave (request, counter control, word stream, status)
module key_word_gen (
    input logic           Clk,
    input logic           Rst,
    key_word_gen_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StClear, StLoad, StExpand, StDone} state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_e       state_q;
    logic [255:0] key_q;
    logic [1:0]   key_len_q;     // normalised: reserved code 3 stored as 0
    logic [31:0]  window_q [8];  // window_q[0] = w[i-1], window_q[Nk-1] = w[i-Nk]
    logic [7:0]   rcon_q;
    logic [2:0]   phase_q;       // i mod Nk, maintained incrementally
    logic         clr_n_q;
    logic         vld_q;
    logic         busy_q;
    logic         done_q;

    logic [2:0]   nk_m1;
    logic [5:0]   last_idx;
    logic         accept;
    logic [31:0]  prev_w;
    logic [31:0]  t_word;
    logic [31:0]  expand_word;
    logic [31:0]  load_word;
    logic [7:0]   load_base;
    logic [31:0]  word_out;

    always_comb begin
        unique case (key_len_q)
            2'd1:    begin nk_m1 = 3'd5; last_idx = 6'd51; end
            2'd2:    begin nk_m1 = 3'd7; last_idx = 6'd59; end
            default: begin nk_m1 = 3'd3; last_idx = 6'd43; end
        endcase
    end

    assign accept = vld_q & bus.Word_Rdy;

    always_comb begin
        prev_w = window_q[0];
        if (phase_q == 3'd0) begin
            t_word = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
        end else if (key_len_q == 2'd2 && phase_q == 3'd4) begin
            t_word = sub_word(prev_w);
        end else begin
            t_word = prev_w;
        end
        expand_word = window_q[nk_m1] ^ t_word;

        // Key word Cnt sits at bit offset 32*(7-Cnt) in the left-aligned key.
        load_base = {3'd7 - bus.Cnt[2:0], 5'd0};
        load_word = key_q[load_base +: 32];

        unique case (state_q)
            StLoad:   word_out = load_word;
            StExpand: word_out = expand_word;
            default:  word_out = 32'h0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= StIdle;
            key_q     <= '0;
            key_len_q <= 2'd0;
            window_q  <= '{default: 32'h0};
            rcon_q    <= 8'h01;
            phase_q   <= 3'd0;
            clr_n_q   <= 1'b1;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.Start) begin
                        key_q     <= bus.Key;
                        key_len_q <= (bus.KeyLen == 2'd3) ? 2'd0 : bus.KeyLen;
                        rcon_q    <= 8'h01;
                        phase_q   <= 3'd0;
                        clr_n_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    clr_n_q <= 1'b1;
                    vld_q   <= 1'b1;
                    state_q <= StLoad;
                end
                StLoad: begin
                    if (accept) begin
                        for (int k = 7; k > 0; k--) window_q[k] <= window_q[k-1];
                        window_q[0] <= word_out;
                        if (bus.Cnt == {3'b000, nk_m1}) begin
                            phase_q <= 3'd0;
                            state_q <= StExpand;
                        end
                    end
                end
                StExpand: begin
                    if (accept) begin
                        for (int k = 7; k > 0; k--) window_q[k] <= window_q[k-1];
                        window_q[0] <= word_out;
                        phase_q <= (phase_q == nk_m1) ? 3'd0 : phase_q + 3'd1;
                        if (phase_q == 3'd0) begin
                            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                        end
                        if (bus.Cnt == last_idx) begin
                            vld_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.Cnt_En    = accept;
    assign bus.Cnt_Clr_n = clr_n_q;
    assign bus.Word_Out  = word_out;
    assign bus.Word_Idx  = vld_q ? bus.Cnt : 6'd0;
    assign bus.Word_Vld  = vld_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
endmodule

// File: tb/tb_key_word_gen.sv
// Self-checking bench for key_word_gen: FIPS-197 vectors for all key sizes, throttled
// handshakes, mid-schedule reset and ignored Start pulses.
module tb_key_word_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_word_gen_if bus ();

    key_word_gen dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    // Key-expansion counter: synchronous active-low clear, saturating at 61.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  bus.Cnt <= 6'd0;
        else if (!bus.Cnt_Clr_n)                   bus.Cnt <= 6'd0;
        else if (bus.Cnt_En && bus.Cnt < 6'd61)    bus.Cnt <= bus.Cnt + 6'd1;
    end

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 =
        {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int          kt;   // 0 = AES-128 key, 1 = AES-192, 2 = AES-256
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input int kt, input int idx, input logic [31:0] exp);
        vec_t v;
        v.kt  = kt;
        v.idx = idx;
        v.exp = exp;
        return v;
    endfunction

    int errors = 0;
    int checks = 0;
    int run    = 0;
    int run_seq = 0;

    // Monitor state (written only by the monitor process)
    int          seen_seq = 0;
    int          cyc = 0;
    int          hs, clr_cnt, done_cnt, done_err, order_err, stall_err, en_err, busy_err;
    int          last_acc;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word;
    logic [5:0]  prev_idx;
    logic [31:0] got [7][64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s run%0d: got %0h expected %0h", name, run, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (seen_seq != run_seq) begin
            seen_seq = run_seq;
            hs = 0; clr_cnt = 0; done_cnt = 0; done_err = 0; order_err = 0;
            stall_err = 0; en_err = 0; busy_err = 0; last_acc = -10;
            for (int i = 0; i < 64; i++) got[run][i] = 32'h0;
        end
        if (rst) begin
            if (!bus.Cnt_Clr_n) clr_cnt++;
            if (bus.Cnt_En !== (bus.Word_Vld & bus.Word_Rdy)) en_err++;
            if (bus.Word_Vld && !bus.Busy) busy_err++;
            if (prev_stall && bus.Word_Vld &&
                (bus.Word_Out !== prev_word || bus.Word_Idx !== prev_idx)) stall_err++;
            if (bus.Done) begin
                done_cnt++;
                if (last_acc != cyc - 1) done_err++;
            end
            if (bus.Word_Vld && bus.Word_Rdy) begin
                if (bus.Word_Idx != hs[5:0] || bus.Word_Idx != bus.Cnt) order_err++;
                got[run][bus.Word_Idx] = bus.Word_Out;
                hs++;
                last_acc = cyc;
            end
            prev_stall = bus.Word_Vld && !bus.Word_Rdy;
            prev_word  = bus.Word_Out;
            prev_idx   = bus.Word_Idx;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    end

    task automatic reset_checks();
        chk("rst_vld",   {63'h0, bus.Word_Vld},  64'h0);
        chk("rst_busy",  {63'h0, bus.Busy},      64'h0);
        chk("rst_done",  {63'h0, bus.Done},      64'h0);
        chk("rst_clr_n", {63'h0, bus.Cnt_Clr_n}, 64'h1);
        chk("rst_word",  {32'h0, bus.Word_Out},  64'h0);
        chk("rst_idx",   {58'h0, bus.Word_Idx},  64'h0);
        chk("rst_cnt_en", {63'h0, bus.Cnt_En},   64'h0);
    endtask

    // One schedule. abort_idx >= 0 pulls Rst low while that word is presented.
    task automatic do_run(input int r, input logic [1:0] kl, input logic [255:0] key,
                          input bit thr, input bit poke, input int abort_idx);
        bit fin = 0;
        int exp_nw;
        exp_nw = (kl == 2'd1) ? 52 : (kl == 2'd2) ? 60 : 44;
        run = r;
        run_seq++;
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.KeyLen = kl; bus.Key = key; bus.Word_Rdy = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            bus.Word_Rdy = thr ? ($urandom_range(0, 9) >= 4) : 1'b1;
            bus.Start = poke && bus.Word_Vld && bus.Word_Idx >= 6'd10 && bus.Word_Idx < 6'd14;
            if (abort_idx >= 0 && bus.Word_Vld && bus.Word_Idx == abort_idx[5:0]) begin
                rst = 1'b0;
                bus.Word_Rdy = 1'b1;
                #1;
                reset_checks();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
            if (bus.Done) fin = 1;
        end
        if (!fin) begin
            chk("timeout", 64'h0, 64'h1);
            return;
        end
        // Now in the DONE cycle: a Start here must be ignored.
        bus.Start = poke;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("handshakes",  hs,        exp_nw);
        chk("clr_pulses",  clr_cnt,   1);
        chk("done_pulses", done_cnt,  1);
        chk("done_timing", done_err,  0);
        chk("order",       order_err, 0);
        chk("stall_hold",  stall_err, 0);
        chk("cnt_en",      en_err,    0);
        chk("busy_vld",    busy_err,  0);
        chk("idle_busy",   {63'h0, bus.Busy},     64'h0);
        chk("idle_vld",    {63'h0, bus.Word_Vld}, 64'h0);
        chk("final_cnt",   {58'h0, bus.Cnt},      exp_nw);
    endtask

    int kt_of [6] = '{0, 1, 2, 0, 2, 0};

    initial begin
        tbl.push_back(mk(0,  0, 32'h2b7e1516));
        tbl.push_back(mk(0,  1, 32'h28aed2a6));
        tbl.push_back(mk(0,  3, 32'h09cf4f3c));
        tbl.push_back(mk(0,  4, 32'ha0fafe17));
        tbl.push_back(mk(0,  5, 32'h88542cb1));
        tbl.push_back(mk(0,  7, 32'h2a6c7605));
        tbl.push_back(mk(0,  8, 32'hf2c295f2));
        tbl.push_back(mk(0, 11, 32'h7359f67f));
        tbl.push_back(mk(0, 40, 32'hd014f9a8));
        tbl.push_back(mk(0, 43, 32'hb6630ca6));
        tbl.push_back(mk(1,  0, 32'h8e73b0f7));
        tbl.push_back(mk(1,  5, 32'h522c6b7b));
        tbl.push_back(mk(1,  6, 32'hfe0c91f7));
        tbl.push_back(mk(1,  7, 32'h2402f5a5));
        tbl.push_back(mk(1, 11, 32'h5c56fec2));
        tbl.push_back(mk(1, 48, 32'he98ba06f));
        tbl.push_back(mk(1, 51, 32'h01002202));
        tbl.push_back(mk(2,  0, 32'h603deb10));
        tbl.push_back(mk(2,  7, 32'h0914dff4));
        tbl.push_back(mk(2,  8, 32'h9ba35411));
        tbl.push_back(mk(2,  9, 32'h8e6925af));
        tbl.push_back(mk(2, 12, 32'ha8b09c1a));
        tbl.push_back(mk(2, 13, 32'h93d194cd));
        tbl.push_back(mk(2, 56, 32'hfe4890d1));
        tbl.push_back(mk(2, 59, 32'h706c631e));

        bus.Start = 1'b0; bus.KeyLen = 2'd0; bus.Key = '0; bus.Word_Rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst = 1'b1;

        do_run(0, 2'd0, K128, 1'b0, 1'b0, -1);
        do_run(1, 2'd1, K192, 1'b0, 1'b0, -1);
        do_run(2, 2'd2, K256, 1'b0, 1'b0, -1);
        do_run(3, 2'd0, K128, 1'b1, 1'b1, -1);
        do_run(6, 2'd0, K128, 1'b0, 1'b0, 20);
        do_run(4, 2'd2, K256, 1'b0, 1'b0, -1);
        do_run(5, 2'd3, K128, 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            run = r;
            foreach (tbl[i]) begin
                if (tbl[i].kt == kt_of[r]) begin
                    chk($sformatf("w%0d", tbl[i].idx), {32'h0, got[r][tbl[i].idx]},
                        {32'h0, tbl[i].exp});
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
